// File: rtl/regfile_scoreboard.sv
// Decode-stage architectural register file with writeback bypass and a
// per-register pending-write scoreboard that stalls issue on RAW hazards
// or when a destination already has the maximum number of writes in flight.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int NREG     = 8,
    parameter int MAX_PEND = 3,
    parameter int AW       = $clog2(NREG),
    parameter int CW       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rdAddr1,
    input  logic [AW-1:0]     rdAddr2,
    input  logic              rdEn1,
    input  logic              rdEn2,
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2,
    input  logic              issue,
    input  logic              issueWrite,
    input  logic [AW-1:0]     issueDst,
    input  logic              wbEn,
    input  logic [AW-1:0]     wbAddr,
    input  logic [DATA_W-1:0] wbData,
    output logic              stall,
    output logic              pendAny,
    output logic              err
);

    logic [DATA_W-1:0] regs     [NREG];
    logic [CW-1:0]     pend_cnt [NREG];
    logic              err_q;

    logic [CW-1:0] eff1, eff2, eff_dst;
    logic          hazard;
    logic          accept;
    logic          inc_en;

    // Pending count seen by this cycle's issue once the concurrent writeback retires.
    function automatic logic [CW-1:0] eff_pend(input logic [AW-1:0] a,
                                               input logic [CW-1:0] cnt,
                                               input logic          wb_en,
                                               input logic [AW-1:0] wb_addr);
        logic [CW-1:0] r;
        r = cnt;
        if (wb_en && (wb_addr == a) && (cnt != '0))
            r = cnt - 1'b1;
        return r;
    endfunction

    // Bypassed read ports, hazard detection and stall generation.
    always_comb begin
        rdData1 = (wbEn && (wbAddr == rdAddr1)) ? wbData : regs[rdAddr1];
        rdData2 = (wbEn && (wbAddr == rdAddr2)) ? wbData : regs[rdAddr2];

        eff1    = eff_pend(rdAddr1, pend_cnt[rdAddr1], wbEn, wbAddr);
        eff2    = eff_pend(rdAddr2, pend_cnt[rdAddr2], wbEn, wbAddr);
        eff_dst = eff_pend(issueDst, pend_cnt[issueDst], wbEn, wbAddr);

        hazard  = (rdEn1 && (eff1 != '0))
               || (rdEn2 && (eff2 != '0))
               || (issueWrite && (eff_dst == CW'(MAX_PEND)));
        stall   = issue && hazard;
        accept  = issue && !hazard;
        inc_en  = accept && issueWrite;
    end

    // Any register with a write still in flight, from registered state only.
    always_comb begin
        pendAny = 1'b0;
        for (int unsigned r = 0; r < NREG; r++)
            if (pend_cnt[AW'(r)] != '0)
                pendAny = 1'b1;
    end

    assign err = err_q;

    // Register storage, scoreboard counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs[AW'(r)]     <= '0;
                pend_cnt[AW'(r)] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wbEn)
                regs[wbAddr] <= wbData;
            for (int unsigned r = 0; r < NREG; r++) begin
                // Increment and decrement of the same register cancel; an
                // unmatched writeback on an empty counter only flags an error.
                if (inc_en && (issueDst == AW'(r)) && !(wbEn && (wbAddr == AW'(r)))) begin
                    pend_cnt[AW'(r)] <= pend_cnt[AW'(r)] + 1'b1;
                end else if (wbEn && (wbAddr == AW'(r)) && !(inc_en && (issueDst == AW'(r)))) begin
                    if (pend_cnt[AW'(r)] != '0)
                        pend_cnt[AW'(r)] <= pend_cnt[AW'(r)] - 1'b1;
                    else
                        err_q <= 1'b1;
                end
            end
        end
    end

endmodule
